// File: rtl/fifo_stream_reader.sv
// ----------------------------------------------------------------------------
// fifo_stream_reader
//
// Drains a show-ahead FIFO into a valid/ready downstream interface through a
// two-entry ordered buffer (head + skid). The FIFO pop decision depends only on
// registered occupancy, so there is no combinational path from out_ready to
// fifo_rdEn, and a full one-entry-per-cycle stream is still sustained.
//
// Ports
//   clk            : single clock, all state updates on the rising edge
//   reset          : asynchronous, active-low reset
//   fifo_read_data : FIFO head entry, valid whenever fifo_empty = 0
//   fifo_empty     : FIFO holds no entries
//   fifo_rdEn      : pop the FIFO head at this rising edge
//   flush          : synchronous discard of all buffered entries
//   out_data       : downstream data (head entry), registered
//   out_valid      : out_data holds a valid entry, registered
//   out_ready      : downstream accepts out_data this cycle
//   beat_count     : number of accepted downstream transfers (wraps)
// ----------------------------------------------------------------------------
module fifo_stream_reader #(
    parameter int DATA_WIDTH  = 32,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [DATA_WIDTH-1:0]  fifo_read_data,
    input  logic                   fifo_empty,
    output logic                   fifo_rdEn,
    input  logic                   flush,
    output logic [DATA_WIDTH-1:0]  out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [COUNT_WIDTH-1:0] beat_count
);

    // Buffer occupancy: number of entries held in head/skid.
    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } occ_t;

    occ_t                   r_occ;
    logic [DATA_WIDTH-1:0]  r_head;
    logic [DATA_WIDTH-1:0]  r_skid;
    logic                   r_valid;
    logic [COUNT_WIDTH-1:0] r_beat;

    logic w_pop;
    logic w_xfer;

    // Gating with reset keeps the pop strobe low while reset is held, without
    // waiting for a clock edge.
    assign w_pop  = reset & ~fifo_empty & ~flush & (r_occ != S_TWO);
    // A flush cycle discards the head, so it never counts as a transfer.
    assign w_xfer = r_valid & out_ready & ~flush;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_occ   <= S_EMPTY;
            r_head  <= '0;
            r_skid  <= '0;
            r_valid <= 1'b0;
            r_beat  <= '0;
        end else begin
            if (w_xfer) begin
                r_beat <= r_beat + COUNT_WIDTH'(1);
            end

            if (flush) begin
                r_occ   <= S_EMPTY;
                r_valid <= 1'b0;
            end else begin
                case (r_occ)
                    S_EMPTY: begin
                        if (w_pop) begin
                            r_head  <= fifo_read_data;
                            r_occ   <= S_ONE;
                            r_valid <= 1'b1;
                        end
                    end
                    S_ONE: begin
                        if (w_pop && w_xfer) begin
                            // Head leaves and the new entry replaces it directly.
                            r_head <= fifo_read_data;
                        end else if (w_pop) begin
                            r_skid <= fifo_read_data;
                            r_occ  <= S_TWO;
                        end else if (w_xfer) begin
                            r_occ   <= S_EMPTY;
                            r_valid <= 1'b0;
                        end
                    end
                    S_TWO: begin
                        // No pop is possible here; only a transfer moves skid up.
                        if (w_xfer) begin
                            r_head <= r_skid;
                            r_occ  <= S_ONE;
                        end
                    end
                    default: begin
                        r_occ   <= S_EMPTY;
                        r_valid <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign fifo_rdEn  = w_pop;
    assign out_data   = r_head;
    assign out_valid  = r_valid;
    assign beat_count = r_beat;

endmodule

// File: doc/fifo_stream_reader.md
FIFO_STREAM_READER -- requirements
Module: fifo_stream_reader

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of FIFO read data and output data.
REQ-002 Parameter COUNT_WIDTH, default 16, width of transfer counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 fifo_read_data  input  DATA_WIDTH  FIFO head entry, valid whenever fifo_empty=0 (show-ahead).
REQ-006 fifo_empty  input  1  FIFO holds no entries.
REQ-007 fifo_rdEn  output  1  pop FIFO head at this rising edge.
REQ-008 flush  input  1  synchronous discard of all buffered entries.
REQ-009 out_data  output  DATA_WIDTH  downstream data, registered.
REQ-010 out_valid  output  1  out_data holds a valid entry, registered.
REQ-011 out_ready  input  1  downstream accepts out_data this cycle.
REQ-012 beat_count  output  COUNT_WIDTH  number of accepted downstream transfers, registered.

Function
REQ-013 Block SHALL hold a 2-entry ordered buffer (head, skid) with occupancy 0, 1 or 2.
REQ-014 fifo_rdEn SHALL equal reset & ~fifo_empty & ~flush & (occupancy != 2); no combinational path from out_ready to fifo_rdEn.
REQ-015 When fifo_rdEn=1, fifo_read_data SHALL be captured at that edge into the buffer tail.
REQ-016 out_valid SHALL equal (occupancy != 0); out_data SHALL equal the head entry.
REQ-017 Transfer SHALL occur when out_valid & out_ready at a rising edge; head is removed, skid (if any) becomes head.
REQ-018 Latency: entry popped at edge N SHALL appear on out_data with out_valid=1 in the cycle after edge N when occupancy was 0 (or was 1 with a simultaneous transfer).
REQ-019 Simultaneous pop and transfer SHALL leave occupancy unchanged; sustained throughput 1 entry/cycle while out_ready=1 and FIFO non-empty.
REQ-020 Pop without transfer SHALL increment occupancy; transfer without pop SHALL decrement it.
REQ-021 While out_valid=1 and out_ready=0, out_data SHALL remain stable and out_valid SHALL remain 1.
REQ-022 Entries SHALL leave in exactly FIFO pop order; no duplication, no loss except via flush.
REQ-023 beat_count SHALL increment by 1 per transfer, modulo 2^COUNT_WIDTH (wraps to 0 after all-ones).
REQ-024 flush=1 at an edge SHALL set occupancy to 0, suppress fifo_rdEn that cycle, and suppress beat_count increment even if out_valid & out_ready.
REQ-025 flush SHALL NOT alter beat_count value or FIFO contents.
REQ-026 fifo_empty=1 SHALL force fifo_rdEn=0 regardless of occupancy.

Reset
REQ-027 reset=0 SHALL immediately force occupancy=0, out_valid=0, out_data=0, beat_count=0, fifo_rdEn=0, independent of clk.
REQ-028 Reset asserted mid-stream SHALL discard buffered entries; first edge after reset release SHALL be a normal cycle (pop allowed if FIFO non-empty).

Verification
REQ-029 After reset release, FIFO holds 100 then 7, out_ready=1 -> fifo_rdEn=1 two consecutive cycles; out_data=100 then 7 with out_valid=1 in the cycles following each pop; beat_count=2.
REQ-030 FIFO holds 51,78,39, out_ready=0 -> two pops then fifo_rdEn=0, occupancy 2, out_data stable at 51; raise out_ready -> 51,78,39 delivered on consecutive cycles, beat_count=3.
REQ-031 Continuous stream 1..8 with out_ready=1 -> one transfer per cycle after 1-cycle fill latency, order 1..8 preserved, beat_count=8.
REQ-032 Occupancy 2 (entries 23,44), flush=1 with out_ready=1 for one cycle -> next cycle out_valid=0, beat_count unchanged, FIFO not popped during flush cycle; next FIFO entry 19 delivered normally.
REQ-033 COUNT_WIDTH=4, 17 transfers -> beat_count=15 after 15th, 0 after 16th, 1 after 17th.
REQ-034 reset asserted asynchronously between edges with occupancy 2 -> out_valid, out_data, beat_count, fifo_rdEn go to 0 before next edge; after release, next FIFO entry 88 delivered first.
